// File: rtl/aftab_aau_pkg.sv
// aftab_aau_pkg: shared opcodes, FSM encoding and decode helpers for the AAU sequencer
package aftab_aau_pkg;
  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;
  localparam logic [31:0] MIN_INT  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  // Returns {signedSigned, signedUnsigned, unsignedUnsigned}
  function automatic logic [2:0] mode_of(input logic [2:0] op);
    return op == F_MULHSU ? 3'b010 : (op[0] && op != F_MULH) ? 3'b001 : 3'b100;
  endfunction
  // Divide: remainder lives in H; multiply: everything but MUL reads H
  function automatic logic sel_high(input logic [2:0] op);
    return op[2] ? op[1] : op != F_MUL;
  endfunction
endpackage

// File: rtl/aftab_aau_special.sv
// aftab_aau_special: detects RISC-V divide corner cases and produces their architectural result
module aftab_aau_special
  import aftab_aau_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        bypass,
  output logic [31:0] value
);
  logic zero, ovf;
  assign zero   = rs2 == '0;
  assign ovf    = !op[0] && rs1 == MIN_INT && rs2 == ALL_ONES;
  assign bypass = op[2] && (zero || ovf);
  assign value  = zero ? (op[1] ? rs1 : ALL_ONES) : (op[1] ? '0 : MIN_INT);
endmodule

// File: rtl/aftab_aau_seq.sv
// aftab_aau_seq: launches one RV32M op on the AAU, waits with timeout, returns the selected word
module aftab_aau_seq
  import aftab_aau_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err,
  output logic [31:0] aauA,
  output logic [31:0] aauB,
  output logic        multAAU,
  output logic        divideAAU,
  output logic        signedSigned,
  output logic        signedUnsigned,
  output logic        unsignedUnsigned,
  input  logic [31:0] aauH,
  input  logic [31:0] aauL,
  input  logic        completeAAU,
  input  logic        dev0
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0]    state;
  logic [2:0]    op;
  logic [CW-1:0] cnt;
  logic          byp, dz_div;
  logic [31:0]   byp_val, dz_val;
  aftab_aau_special u_req (.op(funct3), .rs1(rs1), .rs2(rs2), .bypass(byp), .value(byp_val));
  // Same corner-case logic with a forced zero divisor supplies the dev0 fallback
  aftab_aau_special u_dz (.op(op), .rs1(aauA), .rs2('0), .bypass(dz_div), .value(dz_val));
  assign busy      = state == S_LAUNCH || state == S_WAIT;
  assign done      = state == S_FINISH;
  assign multAAU   = state == S_LAUNCH && !op[2];
  assign divideAAU = state == S_LAUNCH && op[2];
  assign {signedSigned, signedUnsigned, unsignedUnsigned} = busy ? mode_of(op) : 3'b000;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      op     <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
      aauA   <= '0;
      aauB   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op    <= funct3;
          aauA  <= rs1;
          aauB  <= rs2;
          err   <= 1'b0;
          state <= byp ? S_FINISH : S_LAUNCH;
          if (byp) result <= byp_val;
        end
        S_LAUNCH: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: if (completeAAU) begin
          result <= (dev0 && dz_div) ? dz_val : sel_high(op) ? aauH : aauL;
          state  <= S_FINISH;
        end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
          err    <= 1'b1;
          result <= '0;
          state  <= S_FINISH;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/aftab_aau_seq.md
# aftab_aau_seq

Sequencer between the AFTAB execute-stage control and the `aftab_AAU` multiply/divide unit. It accepts one RV32M operation per request and decodes funct3 into AAU mode strobes. It holds the operands stable while the AAU works, waits for `completeAAU`, and returns the selected 32-bit result to the core. RISC-V divide-by-zero and signed-overflow cases are resolved locally, without launching the AAU.

## Interface
- `TIMEOUT_CYCLES`, default 64: number of WAIT cycles without `completeAAU` after which the operation aborts with `err`.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-low. `rst=0` resets the block on the next rising edge.
- `start` in 1: request strobe; sampled only when `busy=0`.
- `funct3` in 3: operation select.
  - MUL=000, MULH=001, MULHSU=010, MULHU=011
  - DIV=100, DIVU=101, REM=110, REMU=111
- `rs1`, `rs2` in 32: operands.
- `busy` out 1: an operation is in flight.
- `done` out 1: one-cycle pulse; `result` and `err` are valid in that cycle.
- `result` out 32: registered result, held until the next `done`.
- `err` out 1: timeout flag, valid with `done`.
- `aauA`, `aauB` out 32: operands to the AAU, registered.
- `multAAU`, `divideAAU` out 1: AAU launch strobes.
- `signedSigned`, `signedUnsigned`, `unsignedUnsigned` out 1: AAU sign mode, one-hot while busy.
- `aauH`, `aauL` in 32: AAU outputs.
  - Multiply: H = high word, L = low word.
  - Divide: L = quotient, H = remainder.
- `completeAAU` in 1: AAU finished.
- `dev0` in 1: AAU divide-by-zero flag.

## Operation
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE, `start=1`: latch `funct3`, `rs1` and `rs2` into `aauA`/`aauB` and an op register; set `busy=1`.
  - Bypass case: go to FINISH.
  - Otherwise: go to LAUNCH.
- Bypass cases, with the AAU never strobed:
  - DIV/DIVU/REM/REMU with `rs2=0`: quotient ops return `0xFFFFFFFF`; remainder ops return `rs1`.
  - DIV/REM with `rs1=0x80000000` and `rs2=0xFFFFFFFF`: DIV returns `0x80000000`; REM returns 0.
- Mode decode:
  - MUL, MULH, DIV, REM: `signedSigned`.
  - MULHSU: `signedUnsigned`.
  - MULHU, DIVU, REMU: `unsignedUnsigned`.
- LAUNCH: `multAAU` (funct3[2]=0) or `divideAAU` (funct3[2]=1) is high for exactly this one cycle. Clear the timeout counter, then go to WAIT.
- WAIT: the counter increments each cycle.
  - `completeAAU=1`: capture the result, go to FINISH.
  - Counter reaches `TIMEOUT_CYCLES`: set `err=1`, `result=0`, go to FINISH.
- Result select:
  - MUL: `aauL`.
  - MULH, MULHSU, MULHU: `aauH`.
  - DIV, DIVU: `aauL`.
  - REM, REMU: `aauH`.
  - If `dev0=1` arrives with `completeAAU`, the divide-by-zero bypass values are used instead.
- FINISH: `done=1`, `busy=0` in the same cycle; go to IDLE.
- `start` while `busy=1`, or in the FINISH cycle, is ignored and not queued.
- Mode strobes stay one-hot from LAUNCH through WAIT and are 0 in IDLE/FINISH. `aauA`/`aauB` do not change while busy.

## Timing
- Reset values:
  - State IDLE.
  - `busy`, `done`, `err`, `multAAU`, `divideAAU` and all mode strobes 0.
  - `result`, `aauA`, `aauB` 0.
- `rst=0` mid-operation: IDLE on the next edge, strobes drop, no `done`. A `completeAAU` arriving later is ignored.
- Request at edge 0:
  - LAUNCH in cycle 1.
  - WAIT from cycle 2.
  - If `completeAAU` is sampled high at edge n, `done` is high in cycle n+1.
- Bypass: `done` in cycle 1.
- Back-to-back: a new `start` is accepted in the cycle after `done`.
- `completeAAU` during LAUNCH is ignored; the AAU only completes in WAIT.

## Structure
- Shared package `aftab_aau_pkg`:
  - funct3 opcode constants.
  - State encoding.
  - `MIN_INT=32'h80000000` and `ALL_ONES=32'hFFFFFFFF`.
- One natural sub-module: `aftab_aau_special`, combinational. It detects the bypass cases and produces the bypass result from op, `rs1` and `rs2`. It is reused for the `dev0` path.
- Single FSM plus a `$clog2(TIMEOUT_CYCLES+1)`-bit counter.
- Estimated 150–250 lines of RTL.

## Test plan
- MUL, 40 × `0xFFFFFFFE` → `multAAU` pulses for exactly one cycle with `signedSigned=1`; `result=0xFFFFFFB0`, `done` one cycle after `completeAAU`.
- MULH and MULHSU, with `rs1=1`, `rs2=0xFFFFFFFE` → `0xFFFFFFFF` and 0 respectively. Check the mode strobe for each op.
- DIV, `0xFFFFFF88` (−120) / 7 → `0xFFFFFFEF`; REM on the same operands → `0xFFFFFFFF`. REMU, 121 / 7 → 2; DIVU → 17.
- DIVU, 5 / 0 → `done` in cycle 1, `result=0xFFFFFFFF`, `divideAAU` never high. REM, 5 / 0 → 5. DIV, `0x80000000` / `0xFFFFFFFF` → `0x80000000`.
- AAU stub that never completes → `err=1` and `result=0` with `done` at cycle `TIMEOUT_CYCLES+3`. Then `start` in the next cycle is accepted.
- `rst=0` during WAIT, with `start` pulsed while busy beforehand → no spurious `done`, all outputs at reset values. The ignored `start` produces no second operation.
